bus_share_arbiter: RTL and testbench
====================================

Name: bus_share_arbiter

Overview:
- Two-requester arbiter that shares one 32-bit 2:1 word multiplexer and a registered output port between two sources, for example the register-file write-back and the memory-load return.
- Drives the mux select, issues per-beat grants, limits burst length with round-robin fairness, and registers the selected word behind a valid/ready handshake.
- Sits between the two producers and the single downstream consumer.

Parameters:
WIDTH, 32, data word width (mux width).
MAX_BURST, 4, max consecutive accepted beats per ownership while the other side is requesting; must be >= 1.
CNT_W, 2, width of the burst counter; must be >= clog2(MAX_BURST).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
req1  input  1  requester 1 has a beat available on data1.
data1  input  WIDTH  requester 1 word (mux option1).
gnt1  output  1  requester 1 beat accepted this cycle (combinational).
req2  input  1  requester 2 has a beat available on data2.
data2  input  WIDTH  requester 2 word (mux option2).
gnt2  output  1  requester 2 beat accepted this cycle (combinational).
sel  output  1  mux select: 1 selects option1/data1, 0 selects option2/data2 (registered).
out_valid  output  1  out_data holds a valid beat.
out_data  output  WIDTH  registered selected word.
out_src  output  1  source of out_data: 1 = requester 1, 0 = requester 2.
out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high, sampled on the rising edge. While reset is high: state = IDLE, sel = 1, priority points to requester 1, beat_cnt = 0, out_valid = 0, out_data = 0, out_src = 0. gnt1 and gnt2 are 0 during reset.
- A reset mid-burst discards the registered beat. No grant is issued in the reset cycle.
- can_accept = !out_valid | out_ready. The output register never overflows or drops a beat.
- FSM states are IDLE, OWN1 and OWN2.
- IDLE:
  - No grants.
  - If only reqX is high, go to OWNX.
  - If both are high, go to the side holding priority, then flip priority to the other side.
  - Otherwise stay in IDLE.
  - Arbitration costs exactly 1 cycle.
- OWNX:
  - sel = (X==1).
  - gntX = reqX & can_accept. The other gnt is 0.
  - On gntX, load out_data from the mux output (dataX), set out_src = (X==1), set out_valid = 1, and increment beat_cnt.
- Leaving OWNX, evaluated at the clock edge:
  - (a) reqX low: if reqY is high, go to OWNY, set priority = X, beat_cnt = 0; else go to IDLE, beat_cnt = 0.
  - (b) gntX with beat_cnt == MAX_BURST-1 and reqY high: forced rotation to OWNY, beat_cnt = 0, priority = X.
  - (c) gntX with beat_cnt == MAX_BURST-1 and reqY low: stay in OWNX, beat_cnt wraps to 0.
- sel is registered and updates on entry to OWN1/OWN2. It holds its last value in IDLE.
- out_valid clears when out_ready is high and no grant occurs that cycle. A grant and an out_ready in the same cycle replace the word back-to-back, giving full throughput.
- Latency: req rises in IDLE at cycle 0 -> gnt at cycle 1 (if can_accept) -> out_valid at cycle 2.
- Requester contract: dataX is held stable while reqX is high and gntX is low. reqX may drop at any cycle, and an ungranted beat is then withdrawn.
- Stall (out_valid high, out_ready low): no grants and the state is held. Rotation and req-drop exits still apply.

Test Plan:
- Reset with req1 = req2 = 1 -> gnt1 = gnt2 = 0 and out_valid = 0 during reset. The first cycle after reset is IDLE. The next cycle has sel = 1 and gnt1 = 1; out_data = data1 one cycle later.
- Only req2 held, data2 = 0xA5A5_0000 + n, out_ready = 1 -> gnt2 every cycle after the 1-cycle arbitration. There are 8 consecutive beats with no rotation, and out_src = 0.
- req1 and req2 both held, out_ready = 1, MAX_BURST = 4 -> grant pattern is gnt1 x4, gnt2 x4, gnt1 x4, and so on, with no idle cycles between owners. sel toggles on each rotation.
- OWN1 with out_ready = 0 for 3 cycles -> out_data is held at 0xDEAD_BEEF and out_valid stays 1 with no grants. When out_ready returns to 1, the next beat is granted in the same cycle.
- req1 drops after 2 beats while req2 is high -> state goes to OWN2 the next cycle with beat_cnt = 0. A later simultaneous request from IDLE goes to requester 2 (priority flipped).
- Reset asserted mid-burst with out_valid = 1 -> the next cycle shows out_valid = 0, sel = 1, state IDLE, and no grant.

Source files
------------

// File: rtl/bus_share_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 word mux and a
// registered valid/ready output port, with burst-length limited ownership.
module bus_share_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  input  logic             req2,
  input  logic [WIDTH-1:0] data2,
  output logic             gnt2,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_prio;       // 1: requester 1 wins the next tie in IDLE
  logic               w_prio_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_sel;
  logic               w_sel_nxt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_src;

  logic               w_can_accept;
  logic               w_last;
  logic               w_gnt1;
  logic               w_gnt2;
  logic               w_load;
  logic [WIDTH-1:0]   w_mux;

  assign w_can_accept = !r_out_valid || out_ready;
  assign w_last       = (r_cnt == CNT_W'(MAX_BURST - 1));
  assign w_mux        = r_sel ? data1 : data2;
  assign w_load       = w_gnt1 || w_gnt2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_prio  <= 1'b1;
      r_cnt   <= '0;
      r_sel   <= 1'b1;
    end else begin
      r_state <= w_next;
      r_prio  <= w_prio_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_prio_nxt = r_prio;
    w_cnt_nxt  = r_cnt;
    w_gnt1     = 1'b0;
    w_gnt2     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req1 && req2) begin
          w_next     = r_prio ? OWN1 : OWN2;
          w_prio_nxt = !r_prio;
        end else if (req1) begin
          w_next = OWN1;
        end else if (req2) begin
          w_next = OWN2;
        end
      end
      OWN1: begin
        w_gnt1 = req1 && w_can_accept;
        if (!req1) begin
          w_cnt_nxt = '0;
          if (req2) begin
            w_next     = OWN2;
            w_prio_nxt = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end else if (w_gnt1) begin
          if (w_last) begin
            // Burst limit: rotate if the other side waits, else wrap and keep ownership
            w_cnt_nxt = '0;
            if (req2) begin
              w_next     = OWN2;
              w_prio_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      OWN2: begin
        w_gnt2 = req2 && w_can_accept;
        if (!req2) begin
          w_cnt_nxt = '0;
          if (req1) begin
            w_next     = OWN1;
            w_prio_nxt = 1'b0;
          end else begin
            w_next = IDLE;
          end
        end else if (w_gnt2) begin
          if (w_last) begin
            w_cnt_nxt = '0;
            if (req1) begin
              w_next     = OWN1;
              w_prio_nxt = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
    if (reset) begin
      w_gnt1 = 1'b0;
      w_gnt2 = 1'b0;
    end
  end

  // Select is set on entry to an owner state and simply held through IDLE
  always_comb begin
    w_sel_nxt = r_sel;
    if (w_next == OWN1) begin
      w_sel_nxt = 1'b1;
    end else if (w_next == OWN2) begin
      w_sel_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux;
      r_out_src   <= r_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign gnt1      = w_gnt1;
  assign gnt2      = w_gnt2;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed self-checking bench for bus_share_arbiter: reset, single-owner
// streaming, burst rotation, output stall, req-drop exit and mid-burst reset.
module tb_bus_share_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt1;
  logic             req2;
  logic [WIDTH-1:0] data2;
  logic             gnt2;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  int unsigned n_checks;
  int unsigned n_errors;

  bus_share_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (4),
    .CNT_W     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req1      (req1),
    .data1     (data1),
    .gnt1      (gnt1),
    .req2      (req2),
    .data2     (data2),
    .gnt2      (gnt2),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req1  = 1'b0;
    req2  = 1'b0;
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    logic prev_src;
    logic exp_g1;
    n_checks  = 0;
    n_errors  = 0;

    // Reset with both requesters active
    reset     = 1'b1;
    req1      = 1'b1;
    req2      = 1'b1;
    data1     = 32'h1111_0001;
    data2     = 32'h2222_0002;
    out_ready = 1'b1;
    mid();
    check_eq("rst_gnt1", gnt1, 0);
    check_eq("rst_gnt2", gnt2, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_sel", sel, 1);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_src", out_src, 0);
    nxt();
    reset = 1'b0;
    mid();
    check_eq("arb_gnt1", gnt1, 0);
    check_eq("arb_gnt2", gnt2, 0);
    nxt();

    // Both held: gnt1 x4, gnt2 x4, gnt1 x4 with no idle gap
    prev_src = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_g1 = ((i / 4) % 2) == 0;
      mid();
      check_eq("rr_gnt1", gnt1, exp_g1);
      check_eq("rr_gnt2", gnt2, !exp_g1);
      check_eq("rr_sel", sel, exp_g1);
      if (i >= 1) begin
        check_eq("rr_valid", out_valid, 1);
        check_eq("rr_src", out_src, prev_src);
        check_eq("rr_data", out_data, prev_src ? 64'h1111_0001 : 64'h2222_0002);
      end
      prev_src = exp_g1;
      nxt();
    end

    // Only requester 2, eight beats, no rotation
    do_reset();
    req2  = 1'b1;
    data2 = 32'hA5A5_0000;
    mid();
    check_eq("s2_idle_gnt2", gnt2, 0);
    nxt();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) data2 = 32'hA5A5_0000 + 32'(k);
      else       req2 = 1'b0;
      mid();
      if (k < 8) begin
        check_eq("s2_gnt2", gnt2, 1);
        check_eq("s2_gnt1", gnt1, 0);
        check_eq("s2_sel", sel, 0);
      end
      if (k >= 1) begin
        check_eq("s2_valid", out_valid, 1);
        check_eq("s2_src", out_src, 0);
        check_eq("s2_data", out_data, 64'hA5A5_0000 + 64'(k - 1));
      end
      nxt();
    end

    // Output stall while owning requester 1
    do_reset();
    req1  = 1'b1;
    data1 = 32'hDEAD_BEEF;
    mid();
    nxt();
    mid();
    check_eq("st_gnt_first", gnt1, 1);
    nxt();
    out_ready = 1'b0;
    data1     = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      mid();
      check_eq("st_gnt1", gnt1, 0);
      check_eq("st_valid", out_valid, 1);
      check_eq("st_data", out_data, 64'hDEAD_BEEF);
      nxt();
    end
    out_ready = 1'b1;
    mid();
    check_eq("st_resume_gnt1", gnt1, 1);
    nxt();
    req1 = 1'b0;
    mid();
    check_eq("st_new_data", out_data, 64'h1234_5678);
    check_eq("st_new_valid", out_valid, 1);
    nxt();

    // Req-drop exit to OWN2 with counter cleared, then priority after rotation
    do_reset();
    req1  = 1'b1;
    data1 = 32'hC1C1_0001;
    data2 = 32'hC2C2_0002;
    mid();
    nxt();
    req2 = 1'b1;
    mid();
    check_eq("rd_gnt1_a", gnt1, 1);
    nxt();
    mid();
    check_eq("rd_gnt1_b", gnt1, 1);
    nxt();
    req1 = 1'b0;
    mid();
    check_eq("rd_drop_gnt1", gnt1, 0);
    check_eq("rd_drop_gnt2", gnt2, 0);
    nxt();
    req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      check_eq("rd_own2_gnt2", gnt2, 1);
      check_eq("rd_own2_gnt1", gnt1, 0);
      check_eq("rd_own2_sel", sel, 0);
      nxt();
    end
    mid();
    check_eq("rd_rot_gnt1", gnt1, 1);
    check_eq("rd_rot_sel", sel, 1);
    nxt();
    req1 = 1'b0;
    req2 = 1'b0;
    mid();
    check_eq("rd_exit_gnt1", gnt1, 0);
    nxt();
    req1 = 1'b1;
    req2 = 1'b1;
    mid();
    check_eq("rd_idle_gnt1", gnt1, 0);
    check_eq("rd_idle_gnt2", gnt2, 0);
    nxt();
    mid();
    check_eq("rd_tie_gnt2", gnt2, 1);
    check_eq("rd_tie_gnt1", gnt1, 0);
    check_eq("rd_tie_sel", sel, 0);
    nxt();

    // Reset asserted mid-burst with a valid beat held
    reset = 1'b1;
    mid();
    check_eq("mr_valid_before", out_valid, 1);
    check_eq("mr_gnt1_inrst", gnt1, 0);
    check_eq("mr_gnt2_inrst", gnt2, 0);
    nxt();
    reset = 1'b0;
    mid();
    check_eq("mr_valid", out_valid, 0);
    check_eq("mr_sel", sel, 1);
    check_eq("mr_data", out_data, 0);
    check_eq("mr_gnt1", gnt1, 0);
    check_eq("mr_gnt2", gnt2, 0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
